// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a synchronous-read single-port memory.
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          req_a, req_b;
  logic          we_a, we_b;
  logic          lock_a, lock_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wd_a, wd_b;
  logic          gnt_a, gnt_b;
  logic          rvalid_a, rvalid_b;
  logic [DW-1:0] rd_a, rd_b;
  logic          mem_en, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  req_a, req_b, we_a, we_b, lock_a, lock_b,
    input  addr_a, addr_b, wd_a, wd_b, mem_rd,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rd_a, rd_b,
    output mem_en, mem_wen, mem_addr, mem_wd
  );

  modport master (
    output req_a, req_b, we_a, we_b, lock_a, lock_b,
    output addr_a, addr_b, wd_a, wd_b, mem_rd,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rd_a, rd_b,
    input  mem_en, mem_wen, mem_addr, mem_wd
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter with bounded lock tenure and a
// tagged read-return pipeline matching a 1-cycle synchronous-read memory.
module mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_LOCK = 4
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  localparam logic [4:0] MaxLockW = 5'(MAX_LOCK);

  state_e        state_q, state_d;
  logic          rr_q, rr_d;
  logic [3:0]    lock_cnt_q, lock_cnt_d;
  logic [4:0]    cnt_inc;

  logic          gnt_a, gnt_b, acc, sel_b, sel_we, sel_lock;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wd;

  logic          mem_en_q, mem_wen_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wd_q;
  logic          tag_a_q, tag_b_q;
  logic          rvalid_a_q, rvalid_b_q;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_a && (!bus.req_b || !rr_q)) gnt_a = 1'b1;
          else if (bus.req_b)                     gnt_b = 1'b1;
        end
        OWN_A:   gnt_a = bus.req_a;
        OWN_B:   gnt_b = bus.req_b;
        default: ;
      endcase
    end
  end

  assign acc      = gnt_a | gnt_b;
  assign sel_b    = gnt_b;
  assign sel_we   = sel_b ? bus.we_b   : bus.we_a;
  assign sel_lock = sel_b ? bus.lock_b : bus.lock_a;
  assign sel_addr = sel_b ? bus.addr_b : bus.addr_a;
  assign sel_wd   = sel_b ? bus.wd_b   : bus.wd_a;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_cnt_d = lock_cnt_q;
    cnt_inc    = {1'b0, lock_cnt_q} + 5'd1;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          if (sel_lock && (MAX_LOCK > 1)) begin
            state_d    = sel_b ? OWN_B : OWN_A;
            lock_cnt_d = 4'd1;
          end else begin
            rr_d = ~sel_b;
          end
        end
      end
      OWN_A, OWN_B: begin
        // No acceptance while owning means the owner dropped req: release.
        if (acc && sel_lock && (cnt_inc < MaxLockW)) begin
          lock_cnt_d = cnt_inc[3:0];
        end else begin
          state_d    = IDLE;
          rr_d       = (state_q == OWN_A);
          lock_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      lock_cnt_q <= '0;
      mem_en_q   <= 1'b0;
      mem_wen_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      tag_a_q    <= 1'b0;
      tag_b_q    <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_cnt_q <= lock_cnt_d;
      mem_en_q   <= acc;
      mem_wen_q  <= acc & sel_we;
      if (acc) begin
        mem_addr_q <= sel_addr;
        mem_wd_q   <= sel_wd;
      end
      tag_a_q    <= acc & ~sel_we & ~sel_b;
      tag_b_q    <= acc & ~sel_we & sel_b;
      rvalid_a_q <= tag_a_q;
      rvalid_b_q <= tag_b_q;
    end
  end

  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.mem_en   = mem_en_q;
  assign bus.mem_wen  = mem_wen_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wd   = mem_wd_q;
  assign bus.rvalid_a = rvalid_a_q;
  assign bus.rvalid_b = rvalid_b_q;
  assign bus.rd_a     = bus.mem_rd;
  assign bus.rd_b     = bus.mem_rd;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter AW, default 8, meaning memory address width.
REQ-002 The module SHALL have parameter DW, default 16, meaning memory data width.
REQ-003 The module SHALL have parameter MAX_LOCK, default 4, meaning the maximum number of consecutive locked transactions per tenure (range 1..15).
REQ-004 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Ports req_a/req_b  input  1  each requester's transaction request.
REQ-007 Ports we_a/we_b  input  1  per-requester write (1) or read (0).
REQ-008 Ports lock_a/lock_b  input  1  per-requester request to keep ownership after this transaction.
REQ-009 Ports addr_a/addr_b  input  AW  per-requester address.
REQ-010 Ports wd_a/wd_b  input  DW  per-requester write data.
REQ-011 Ports gnt_a/gnt_b  output  1  combinational grant; a transaction is accepted at a rising edge where req_x and gnt_x are both 1.
REQ-012 Ports rvalid_a/rvalid_b  output  1  read data valid, one cycle per accepted read.
REQ-013 Ports rd_a/rd_b  output  DW  read data, meaningful only while rvalid_x=1.
REQ-014 Port mem_en  output  1  memory command strobe.
REQ-015 Port mem_wen  output  1  memory write enable.
REQ-016 Port mem_addr  output  AW  memory address.
REQ-017 Port mem_wd  output  DW  memory write data.
REQ-018 Port mem_rd  input  DW  memory read data, valid one cycle after the command edge (synchronous-read single-port memory).

Function
REQ-019 At most one of gnt_a/gnt_b SHALL be 1 in any cycle; gnt_x SHALL never be 1 while req_x=0.
REQ-020 The FSM SHALL have states IDLE, OWN_A and OWN_B, plus a 1-bit round-robin pointer rr (A or B) and a lock counter lock_cnt.
REQ-021 In IDLE with a single requester asserting req, that requester SHALL be granted.
REQ-022 In IDLE with both req_a=1 and req_b=1, the port indicated by rr SHALL be granted.
REQ-023 In IDLE, an acceptance with lock_x=0 SHALL keep the FSM in IDLE and set rr to the other port.
REQ-024 In IDLE, an acceptance with lock_x=1 SHALL move the FSM to OWN_X with lock_cnt=1; if MAX_LOCK=1, the FSM SHALL instead stay in IDLE and set rr to the other port.
REQ-025 In OWN_X, only port X SHALL be granted; the other port SHALL stall regardless of its req.
REQ-026 In OWN_X, an acceptance with lock_x=1 and lock_cnt+1<MAX_LOCK SHALL increment lock_cnt and keep the FSM in OWN_X.
REQ-027 In OWN_X, an acceptance with lock_x=0, or the acceptance that makes lock_cnt+1=MAX_LOCK, SHALL move the FSM to IDLE and set rr to the other port.
REQ-028 In OWN_X, a cycle with req_x=0 SHALL move the FSM to IDLE and set rr to the other port, with no grant that cycle.
REQ-029 An acceptance at edge N SHALL register mem_en=1, mem_wen=we_x, mem_addr=addr_x and mem_wd=wd_x for the one cycle following edge N.
REQ-030 In every cycle without an acceptance at the preceding edge, mem_en and mem_wen SHALL be 0.
REQ-031 A read accepted at edge N SHALL produce rvalid_x=1 with rd_x=mem_rd in the cycle following edge N+1 (2-cycle latency); the requester tag SHALL be pipelined alongside the command.
REQ-032 Writes SHALL produce no rvalid.
REQ-033 Back-to-back acceptances SHALL sustain 1 transaction per cycle, with rvalid for successive reads on consecutive cycles in acceptance order.
REQ-034 A read following a write to the same address SHALL return the new data, since memory order equals acceptance order.

Reset
REQ-035 While rst_n=0, state SHALL be IDLE, rr=A, lock_cnt=0, mem_en=0, mem_wen=0, mem_addr=0, mem_wd=0, rvalid_a=0, rvalid_b=0, and all read-tag pipeline stages 0.
REQ-036 gnt_a and gnt_b SHALL be 0 while rst_n=0.
REQ-037 rd_a and rd_b SHALL follow mem_rd and are don't-care while their rvalid is 0.
REQ-038 Assertion of rst_n=0 mid-transaction SHALL immediately drop in-flight commands and pending reads, with no rvalid after reset release.

Verification
REQ-039 Single write then read on A (write 0x0010 to 0x11, then read 0x11) -> mem_en/mem_wen pulse with mem_addr 0x11 and mem_wd 0x0010; rvalid_a=1 with rd_a=0x0010 two cycles after the read acceptance.
REQ-040 req_a=req_b=1 continuously, both unlocked, from reset -> grants alternate A,B,A,B and no port waits more than 1 cycle.
REQ-041 lock_a=1 held with req_a and req_b continuously high, MAX_LOCK=4 -> A is granted 4 consecutive cycles, then B, then A.
REQ-042 In OWN_B, B drops req for 1 cycle while A requests -> FSM goes to IDLE with no grant that cycle, then A is granted next.
REQ-043 Reads to 0x20, 0x21 and 0x22 accepted back-to-back from B -> three consecutive rvalid_b cycles with data in address order.
REQ-044 rst_n pulsed low one cycle after a read acceptance -> no rvalid ever appears, and all outputs hold their reset values during reset.
